// File: rtl/arith_rs.sv
// Reservation station for the arithmetic unit: compacting queue, CDB snoop, oldest-ready issue.
// Optional macro ARITH_RS_WAKEUP_ISSUE_EN lets an entry issue in the same cycle as its wakeup broadcast.
module arith_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       dispatch_valid_i,
  output logic                       dispatch_ready_o,
  input  logic [31:0]                dispatch_pc_i,
  input  logic [31:0]                dispatch_inst_i,
  input  logic [TAG_W-1:0]           dispatch_rd_tag_i,
  input  logic                       dispatch_rs1_rdy_i,
  input  logic [TAG_W-1:0]           dispatch_rs1_tag_i,
  input  logic [31:0]                dispatch_rs1_value_i,
  input  logic                       dispatch_rs2_rdy_i,
  input  logic [TAG_W-1:0]           dispatch_rs2_tag_i,
  input  logic [31:0]                dispatch_rs2_value_i,
  input  logic                       cdb_valid_i,
  input  logic [TAG_W-1:0]           cdb_tag_i,
  input  logic [31:0]                cdb_value_i,
  input  logic                       alu_ready_i,
  output logic                       alu_request_o,
  output logic [31:0]                pc_o,
  output logic [31:0]                inst_o,
  output logic [31:0]                rs1_value_o,
  output logic [31:0]                rs2_value_o,
  output logic [TAG_W-1:0]           issue_tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] rd_tag;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs1_val;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs2_val;
  } entry_t;

  entry_t           ent_r [DEPTH];
  entry_t           upd_s [DEPTH+1];
  entry_t           nxt_s [DEPTH];
  entry_t           disp_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [CW-1:0]    wpos_s;
  logic [DEPTH-1:0] w1_s;
  logic [DEPTH-1:0] w2_s;
  logic [DEPTH-1:0] rdy_s;
  logic [DEPTH-1:0] shift_s;
  logic             any_rdy_s;
  logic             issue_fire_s;
  logic             dispatch_fire_s;
  logic             m1_s;
  logic             m2_s;

  assign dispatch_ready_o = (count_r < DEPTH_C);
  assign dispatch_fire_s  = dispatch_valid_i && dispatch_ready_o;
  assign issue_fire_s     = any_rdy_s && alu_ready_i;
  assign alu_request_o    = any_rdy_s;
  assign count_o          = count_r;

  // CDB tag match per stored operand and per-entry readiness
  always_comb begin
    w1_s  = '0;
    w2_s  = '0;
    rdy_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w1_s[i] = cdb_valid_i && ent_r[i].valid && !ent_r[i].rs1_rdy && (ent_r[i].rs1_tag == cdb_tag_i);
      w2_s[i] = cdb_valid_i && ent_r[i].valid && !ent_r[i].rs2_rdy && (ent_r[i].rs2_tag == cdb_tag_i);
`ifdef ARITH_RS_WAKEUP_ISSUE_EN
      rdy_s[i] = ent_r[i].valid && (ent_r[i].rs1_rdy || w1_s[i]) && (ent_r[i].rs2_rdy || w2_s[i]);
`else
      rdy_s[i] = ent_r[i].valid && ent_r[i].rs1_rdy && ent_r[i].rs2_rdy;
`endif
    end
  end

  // Oldest-ready select, issue outputs, and shift mask (every slot at or above the issued one)
  always_comb begin
    any_rdy_s   = 1'b0;
    shift_s     = '0;
    pc_o        = 32'd0;
    inst_o      = 32'd0;
    rs1_value_o = 32'd0;
    rs2_value_o = 32'd0;
    issue_tag_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_s[i] && !any_rdy_s) begin
        pc_o        = ent_r[i].pc;
        inst_o      = ent_r[i].inst;
        issue_tag_o = ent_r[i].rd_tag;
`ifdef ARITH_RS_WAKEUP_ISSUE_EN
        rs1_value_o = w1_s[i] ? cdb_value_i : ent_r[i].rs1_val;
        rs2_value_o = w2_s[i] ? cdb_value_i : ent_r[i].rs2_val;
`else
        rs1_value_o = ent_r[i].rs1_val;
        rs2_value_o = ent_r[i].rs2_val;
`endif
      end else begin
        issue_tag_o = issue_tag_o;
      end
      any_rdy_s  = any_rdy_s | rdy_s[i];
      shift_s[i] = any_rdy_s & alu_ready_i;
    end
  end

  // Incoming entry, including capture of a broadcast that arrives in the dispatch cycle
  always_comb begin
    m1_s           = cdb_valid_i && !dispatch_rs1_rdy_i && (dispatch_rs1_tag_i == cdb_tag_i);
    m2_s           = cdb_valid_i && !dispatch_rs2_rdy_i && (dispatch_rs2_tag_i == cdb_tag_i);
    disp_s         = '0;
    disp_s.valid   = 1'b1;
    disp_s.pc      = dispatch_pc_i;
    disp_s.inst    = dispatch_inst_i;
    disp_s.rd_tag  = dispatch_rd_tag_i;
    disp_s.rs1_rdy = dispatch_rs1_rdy_i | m1_s;
    disp_s.rs1_tag = dispatch_rs1_tag_i;
    disp_s.rs1_val = m1_s ? cdb_value_i : dispatch_rs1_value_i;
    disp_s.rs2_rdy = dispatch_rs2_rdy_i | m2_s;
    disp_s.rs2_tag = dispatch_rs2_tag_i;
    disp_s.rs2_val = m2_s ? cdb_value_i : dispatch_rs2_value_i;
  end

  // Next queue contents: wakeup, compaction past the issued slot, then dispatch write
  always_comb begin
    wpos_s       = count_r - {{(CW-1){1'b0}}, issue_fire_s};
    upd_s[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      upd_s[i] = ent_r[i];
      if (w1_s[i]) begin
        upd_s[i].rs1_rdy = 1'b1;
        upd_s[i].rs1_val = cdb_value_i;
      end else begin
        upd_s[i].rs1_rdy = ent_r[i].rs1_rdy;
      end
      if (w2_s[i]) begin
        upd_s[i].rs2_rdy = 1'b1;
        upd_s[i].rs2_val = cdb_value_i;
      end else begin
        upd_s[i].rs2_rdy = ent_r[i].rs2_rdy;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (dispatch_fire_s && (i[CW-1:0] == wpos_s)) begin
        nxt_s[i] = disp_s;
      end else if (shift_s[i]) begin
        nxt_s[i] = upd_s[i+1];
      end else begin
        nxt_s[i] = upd_s[i];
      end
    end
    count_nxt_s = count_r + {{(CW-1){1'b0}}, dispatch_fire_s} - {{(CW-1){1'b0}}, issue_fire_s};
  end

  // State registers; reset and flush both squash every entry
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else begin
      count_r <= count_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_arith_rs.sv
// Table-driven self-checking bench for arith_rs (DEPTH=4, TAG_W=4).
module tb_arith_rs;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i, flush_i, dispatch_valid_i, dispatch_ready_o;
  logic [31:0] dispatch_pc_i, dispatch_inst_i;
  logic [3:0]  dispatch_rd_tag_i, dispatch_rs1_tag_i, dispatch_rs2_tag_i;
  logic        dispatch_rs1_rdy_i, dispatch_rs2_rdy_i;
  logic [31:0] dispatch_rs1_value_i, dispatch_rs2_value_i;
  logic        cdb_valid_i;
  logic [3:0]  cdb_tag_i;
  logic [31:0] cdb_value_i;
  logic        alu_ready_i, alu_request_o;
  logic [31:0] pc_o, inst_o, rs1_value_o, rs2_value_o;
  logic [3:0]  issue_tag_o;
  logic [2:0]  count_o;

  arith_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_pc_i(dispatch_pc_i), .dispatch_inst_i(dispatch_inst_i),
    .dispatch_rd_tag_i(dispatch_rd_tag_i),
    .dispatch_rs1_rdy_i(dispatch_rs1_rdy_i), .dispatch_rs1_tag_i(dispatch_rs1_tag_i),
    .dispatch_rs1_value_i(dispatch_rs1_value_i),
    .dispatch_rs2_rdy_i(dispatch_rs2_rdy_i), .dispatch_rs2_tag_i(dispatch_rs2_tag_i),
    .dispatch_rs2_value_i(dispatch_rs2_value_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
    .alu_ready_i(alu_ready_i), .alu_request_o(alu_request_o),
    .pc_o(pc_o), .inst_o(inst_o), .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o),
    .issue_tag_o(issue_tag_o), .count_o(count_o)
  );

  typedef struct {
    logic dv; logic [31:0] pc; logic [3:0] rd;
    logic r1; logic [3:0] t1; logic [31:0] v1;
    logic r2; logic [3:0] t2; logic [31:0] v2;
    logic cv; logic [3:0] ct; logic [31:0] cval;
    logic ar; logic fl; logic rst;
    logic e_dr; logic e_req; logic [31:0] e_pc; logic [31:0] e_r1; logic [31:0] e_r2;
    logic [3:0] e_tag; logic [2:0] e_cnt;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  vec_t tbl [$];

  function automatic vec_t N();
    vec_t v;
    v = '{default: '0};
    v.ar = 1'b1;
    return v;
  endfunction

  function automatic vec_t D(input logic [31:0] pc, input logic [3:0] rd,
                             input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                             input logic r2, input logic [3:0] t2, input logic [31:0] v2);
    vec_t v;
    v = N();
    v.dv = 1'b1; v.pc = pc; v.rd = rd;
    v.r1 = r1; v.t1 = t1; v.v1 = v1;
    v.r2 = r2; v.t2 = t2; v.v2 = v2;
    return v;
  endfunction

  function automatic vec_t C(input vec_t vi, input logic [3:0] ct, input logic [31:0] cval);
    vec_t v;
    v = vi; v.cv = 1'b1; v.ct = ct; v.cval = cval;
    return v;
  endfunction

  function automatic vec_t H(input vec_t vi);
    vec_t v;
    v = vi; v.ar = 1'b0;
    return v;
  endfunction

  function automatic vec_t F(input vec_t vi);
    vec_t v;
    v = vi; v.fl = 1'b1;
    return v;
  endfunction

  function automatic vec_t E(input vec_t vi, input logic dr, input logic req, input logic [31:0] pc,
                             input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] tag,
                             input logic [2:0] cnt);
    vec_t v;
    v = vi;
    v.e_dr = dr; v.e_req = req; v.e_pc = pc; v.e_r1 = r1; v.e_r2 = r2; v.e_tag = tag; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic vec_t Z(input vec_t vi, input logic [2:0] cnt);
    return E(vi, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0, cnt);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic run(input vec_t v, input string id);
    logic [31:0] e_inst;
    reset_i = v.rst; flush_i = v.fl; alu_ready_i = v.ar;
    dispatch_valid_i = v.dv; dispatch_pc_i = v.pc; dispatch_inst_i = v.pc ^ 32'h0000_0033;
    dispatch_rd_tag_i = v.rd;
    dispatch_rs1_rdy_i = v.r1; dispatch_rs1_tag_i = v.t1; dispatch_rs1_value_i = v.v1;
    dispatch_rs2_rdy_i = v.r2; dispatch_rs2_tag_i = v.t2; dispatch_rs2_value_i = v.v2;
    cdb_valid_i = v.cv; cdb_tag_i = v.ct; cdb_value_i = v.cval;
    e_inst = v.e_req ? (v.e_pc ^ 32'h0000_0033) : 32'd0;
    @(negedge clk);
    chk({id, ".dispatch_ready"}, {31'd0, dispatch_ready_o}, {31'd0, v.e_dr});
    chk({id, ".alu_request"}, {31'd0, alu_request_o}, {31'd0, v.e_req});
    chk({id, ".pc"}, pc_o, v.e_pc);
    chk({id, ".inst"}, inst_o, e_inst);
    chk({id, ".rs1"}, rs1_value_o, v.e_r1);
    chk({id, ".rs2"}, rs2_value_o, v.e_r2);
    chk({id, ".tag"}, {28'd0, issue_tag_o}, {28'd0, v.e_tag});
    chk({id, ".count"}, {29'd0, count_o}, {29'd0, v.e_cnt});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // reset state, single ADDI, no bypass when empty
    tbl.push_back(Z(N(), 3'd0));
    tbl.push_back(Z(D(32'h100, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd0), 3'd0));
    tbl.push_back(E(N(), 1'b1, 1'b1, 32'h100, 32'd5, 32'd0, 4'd3, 3'd1));
    // ADD waiting on tag 7
    tbl.push_back(Z(D(32'h200, 4'd4, 1'b1, 4'd0, 32'h11, 1'b0, 4'd7, 32'd0), 3'd0));
    tbl.push_back(Z(N(), 3'd1));
`ifdef ARITH_RS_WAKEUP_ISSUE_EN
    tbl.push_back(E(C(N(), 4'd7, 32'h2A), 1'b1, 1'b1, 32'h200, 32'h11, 32'h2A, 4'd4, 3'd1));
`else
    tbl.push_back(Z(C(N(), 4'd7, 32'h2A), 3'd1));
    tbl.push_back(E(N(), 1'b1, 1'b1, 32'h200, 32'h11, 32'h2A, 4'd4, 3'd1));
`endif
    // A waits on tag 2, B ready, C waits on tag 2 for both operands
    tbl.push_back(Z(D(32'h300, 4'd5, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd1), 3'd0));
    tbl.push_back(Z(D(32'h304, 4'd6, 1'b1, 4'd0, 32'h10, 1'b1, 4'd0, 32'h20), 3'd1));
    tbl.push_back(E(H(D(32'h308, 4'd7, 1'b0, 4'd2, 32'd0, 1'b0, 4'd2, 32'd0)),
                    1'b1, 1'b1, 32'h304, 32'h10, 32'h20, 4'd6, 3'd2));
    tbl.push_back(E(N(), 1'b1, 1'b1, 32'h304, 32'h10, 32'h20, 4'd6, 3'd3));
`ifdef ARITH_RS_WAKEUP_ISSUE_EN
    tbl.push_back(E(C(N(), 4'd2, 32'h77), 1'b1, 1'b1, 32'h300, 32'h77, 32'd1, 4'd5, 3'd2));
`else
    tbl.push_back(Z(C(N(), 4'd2, 32'h77), 3'd2));
    tbl.push_back(E(N(), 1'b1, 1'b1, 32'h300, 32'h77, 32'd1, 4'd5, 3'd2));
`endif
    tbl.push_back(E(N(), 1'b1, 1'b1, 32'h308, 32'h77, 32'h77, 4'd7, 3'd1));
    tbl.push_back(Z(N(), 3'd0));
    // capture of a broadcast in the dispatch cycle
    tbl.push_back(Z(C(D(32'h400, 4'd8, 1'b0, 4'd9, 32'hDEAD, 1'b1, 4'd0, 32'd2), 4'd9, 32'h55), 3'd0));
    tbl.push_back(E(N(), 1'b1, 1'b1, 32'h400, 32'h55, 32'd2, 4'd8, 3'd1));
    tbl.push_back(Z(N(), 3'd0));
    // tag 1 differs from 9 only in the top bit: no capture
    tbl.push_back(Z(C(D(32'h410, 4'd9, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd3), 4'd1, 32'h99), 3'd0));
    tbl.push_back(Z(N(), 3'd1));
`ifdef ARITH_RS_WAKEUP_ISSUE_EN
    tbl.push_back(E(C(N(), 4'd9, 32'h66), 1'b1, 1'b1, 32'h410, 32'h66, 32'd3, 4'd9, 3'd1));
`else
    tbl.push_back(Z(C(N(), 4'd9, 32'h66), 3'd1));
    tbl.push_back(E(N(), 1'b1, 1'b1, 32'h410, 32'h66, 32'd3, 4'd9, 3'd1));
`endif
    tbl.push_back(Z(N(), 3'd0));
    // fill with ALU stalled, then issue-only when full
    tbl.push_back(Z(H(D(32'h500, 4'd10, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0)), 3'd0));
    tbl.push_back(E(H(D(32'h504, 4'd11, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd0)),
                    1'b1, 1'b1, 32'h500, 32'd0, 32'd0, 4'd10, 3'd1));
    tbl.push_back(E(H(D(32'h508, 4'd12, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd0)),
                    1'b1, 1'b1, 32'h500, 32'd0, 32'd0, 4'd10, 3'd2));
    tbl.push_back(E(H(D(32'h50C, 4'd13, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd0)),
                    1'b1, 1'b1, 32'h500, 32'd0, 32'd0, 4'd10, 3'd3));
    tbl.push_back(E(H(D(32'h5F0, 4'd14, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 32'd0)),
                    1'b0, 1'b1, 32'h500, 32'd0, 32'd0, 4'd10, 3'd4));
    tbl.push_back(E(D(32'h5F0, 4'd14, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 32'd0),
                    1'b0, 1'b1, 32'h500, 32'd0, 32'd0, 4'd10, 3'd4));
    tbl.push_back(E(H(N()), 1'b1, 1'b1, 32'h504, 32'd1, 32'd0, 4'd11, 3'd3));
    // flush beats dispatch, issue and CDB
    tbl.push_back(E(F(C(D(32'h600, 4'd15, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'd7), 4'd1, 32'hAB)),
                    1'b1, 1'b1, 32'h504, 32'd1, 32'd0, 4'd11, 3'd3));
    tbl.push_back(Z(N(), 3'd0));
    tbl.push_back(Z(N(), 3'd0));

    reset_i = 1'b1; flush_i = 1'b0; dispatch_valid_i = 1'b0; cdb_valid_i = 1'b0; alu_ready_i = 1'b1;
    dispatch_pc_i = 32'd0; dispatch_inst_i = 32'd0; dispatch_rd_tag_i = 4'd0;
    dispatch_rs1_rdy_i = 1'b0; dispatch_rs1_tag_i = 4'd0; dispatch_rs1_value_i = 32'd0;
    dispatch_rs2_rdy_i = 1'b0; dispatch_rs2_tag_i = 4'd0; dispatch_rs2_value_i = 32'd0;
    cdb_tag_i = 4'd0; cdb_value_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;

    foreach (tbl[k]) run(tbl[k], $sformatf("v%0d", k));

    // back-to-back dispatch and issue: write lands at count-1
    run(Z(D(32'h700, 4'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1), 3'd0), "tp0");
    run(E(D(32'h704, 4'd2, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd2), 1'b1, 1'b1, 32'h700, 32'd1, 32'd1, 4'd1, 3'd1), "tp1");
    run(E(D(32'h708, 4'd3, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd3), 1'b1, 1'b1, 32'h704, 32'd2, 32'd2, 4'd2, 3'd1), "tp2");
    run(E(N(), 1'b1, 1'b1, 32'h708, 32'd3, 32'd3, 4'd3, 3'd1), "tp3");
    run(Z(N(), 3'd0), "tp4");

    // synchronous reset squashes a pending entry
    run(Z(H(D(32'h800, 4'd4, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 32'd9)), 3'd0), "rs0");
    v = E(C(N(), 4'd4, 32'h1), 1'b1, 1'b1, 32'h800, 32'd8, 32'd9, 4'd4, 3'd1);
    v.rst = 1'b1;
    run(v, "rs1");
    run(Z(N(), 3'd0), "rs2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/arith_rs.md
Name: arith_rs

Overview:
- Reservation station for the arithmetic unit; it is the initiator side of the ALU request interface.
- Buffers dispatched integer ops (OP, OP-IMM, LUI, AUIPC, JAL, JALR) until both source operands are available.
- Captures missing operands by snooping the common data bus (CDB).
- Issues the oldest ready op to the single-cycle arithmetic unit as alu_request/pc/inst/rs1/rs2, tagged with its destination tag.

Parameters:
- DEPTH, 4, number of entries (2..16).
- TAG_W, 4, width of the physical/ROB tag.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous squash of all entries
- dispatch_valid_i  in  1  dispatch request
- dispatch_ready_o  out  1  station can accept a dispatch
- dispatch_pc_i  in  32  instruction PC
- dispatch_inst_i  in  32  raw instruction
- dispatch_rd_tag_i  in  TAG_W  destination tag
- dispatch_rs1_rdy_i  in  1  rs1 value valid at dispatch
- dispatch_rs1_tag_i  in  TAG_W  producer tag when rs1 not ready
- dispatch_rs1_value_i  in  32  rs1 value
- dispatch_rs2_rdy_i, dispatch_rs2_tag_i, dispatch_rs2_value_i  in  1/TAG_W/32  same for rs2
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  TAG_W  broadcast tag
- cdb_value_i  in  32  broadcast value
- alu_ready_i  in  1  ALU/writeback slot accepts an issue
- alu_request_o  out  1  issue valid
- pc_o  out  32  issued PC
- inst_o  out  32  issued instruction
- rs1_value_o  out  32  issued rs1
- rs2_value_o  out  32  issued rs2
- issue_tag_o  out  TAG_W  issued destination tag
- count_o  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Storage: compacting queue. Entry 0 is always the oldest. Each entry holds valid, pc, inst, rd_tag, and per operand {rdy, tag, value}.
- Reset and flush are both synchronous and clear every valid bit on the edge. Flush overrides a dispatch, issue, or CDB event in the same cycle.
- Outputs after reset: dispatch_ready_o=1, alu_request_o=0, count_o=0. pc_o, inst_o, rs1_value_o, rs2_value_o and issue_tag_o are 0 whenever alu_request_o=0.
- dispatch_ready_o = (count < DEPTH), computed from registered state only. A full station stays not-ready even when an issue fires in the same cycle.
- Dispatch fires when dispatch_valid_i && dispatch_ready_o. The entry is written at position count, or count-1 when an issue fires in the same cycle.
- CDB same-cycle capture at dispatch (mandatory): if a dispatched operand has rdy=0, cdb_valid_i=1 and cdb_tag_i matches its tag, store value=cdb_value_i and rdy=1.
- CDB wakeup: every valid entry with an unready operand whose tag matches cdb_tag_i while cdb_valid_i=1 latches the value and sets rdy on the edge. Both operands of one entry may wake on the same broadcast.
- Ready entry: valid && rs1.rdy && rs2.rdy, evaluated on registered state.
- Issue select: combinational; picks the lowest-index ready entry. alu_request_o=1 whenever any entry is ready, and the outputs come from the selected entry.
- The entry is removed on the edge where alu_request_o && alu_ready_i. Younger entries shift down by one in the same edge and keep any CDB capture made that cycle.
- If alu_ready_i=0, nothing is removed and the same entry is presented again next cycle, unless an older entry became ready; oldest-ready selection is re-evaluated every cycle.
- Minimum latency: dispatch with both operands ready at edge N gives alu_request_o=1 in cycle N+1.
- Throughput: 1 dispatch and 1 issue per cycle.
- Empty with a simultaneous dispatch: no issue that cycle; no bypass from dispatch to issue.
- count_o next = count + dispatch_fire - issue_fire.
- Tags are compared on the full TAG_W bits. The station does not check tag uniqueness.

Optional Feature:
- Macro: ARITH_RS_WAKEUP_ISSUE_EN.
- Defined: an entry that is missing only operands matched by the current CDB broadcast counts as ready this cycle. The matching values are forwarded from cdb_value_i onto rs1_value_o/rs2_value_o, and oldest-first priority still applies. Wakeup-to-issue latency is 0 cycles.
- Undefined: the entry becomes ready on the cycle after the broadcast (1-cycle wakeup latency).

Test Plan:
- Reset → count_o=0, dispatch_ready_o=1, alu_request_o=0. Dispatch ADDI, pc=0x100, rs1 ready=5, tag=3 → next cycle alu_request_o=1, pc_o=0x100, rs1_value_o=5, issue_tag_o=3; with alu_ready_i=1, count_o returns to 0.
- Dispatch ADD with rs2 unready (tag 7), then CDB tag=7 value=0x2A two cycles later → issue one cycle after the broadcast (zero cycles with ARITH_RS_WAKEUP_ISSUE_EN) with rs2_value_o=0x2A.
- Dispatch op A (waiting on tag 2), then op B (ready) → B issues first. Broadcast tag 2 → A issues next; entry order is preserved after compaction.
- Dispatch with rs1 tag=9 unready in the same cycle as CDB tag=9 value=0x55 → the entry captures 0x55 and issues the following cycle.
- Fill DEPTH=4 entries with alu_ready_i=0 → dispatch_ready_o=0, count_o=4. Raise alu_ready_i together with a dispatch_valid_i → only the issue fires, count_o=3, next cycle dispatch_ready_o=1.
- 3 entries valid, assert flush_i together with dispatch_valid_i and cdb_valid_i → next cycle count_o=0, alu_request_o=0, no entry written.
